// File: rtl/pak_crc_sequencer.sv
// Byte-to-serial front end for the controller-pak CRC stage: clears the CRC,
// streams a block MSB-first with 8 zero flush bits, then captures the remainder.
module pak_crc_sequencer #(
  parameter int unsigned BLOCK_BYTES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       crc_clr,
  output logic       crc_en,
  output logic       crc_bit,
  input  logic [7:0] crc_rem,
  output logic [7:0] crc_out,
  output logic       crc_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_SHIFT,
    S_FLUSH,
    S_CAPTURE
  } state_t;

  localparam logic [7:0] LAST_BYTE = 8'(BLOCK_BYTES - 1);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_sr;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_byte_cnt;
  logic [7:0] r_crc_out;
  logic       r_crc_valid;

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    crc_clr  = 1'b0;
    crc_en   = 1'b0;
    crc_bit  = 1'b0;
    busy     = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        crc_clr = 1'b1;
        w_next  = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        crc_en  = 1'b1;
        crc_bit = r_sr[7];
        if (r_bit_cnt == 3'd0) begin
          w_next = (r_byte_cnt < LAST_BYTE) ? S_LOAD : S_FLUSH;
        end
      end
      S_FLUSH: begin
        crc_en = 1'b1;
        if (r_bit_cnt == 3'd0) w_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_sr        <= '0;
      r_bit_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_crc_out   <= '0;
      r_crc_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_crc_valid <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          r_byte_cnt <= '0;
        end
        S_LOAD: begin
          if (in_valid) begin
            r_sr      <= in_byte;
            r_bit_cnt <= 3'd7;
          end
        end
        S_SHIFT: begin
          r_sr <= {r_sr[6:0], 1'b0};
          // Reloading 7 on the last bit also arms the 8-cycle flush count.
          if (r_bit_cnt == 3'd0) begin
            r_byte_cnt <= r_byte_cnt + 8'd1;
            r_bit_cnt  <= 3'd7;
          end else begin
            r_bit_cnt <= r_bit_cnt - 3'd1;
          end
        end
        S_FLUSH: begin
          if (r_bit_cnt != 3'd0) r_bit_cnt <= r_bit_cnt - 3'd1;
        end
        S_CAPTURE: begin
          r_crc_out   <= crc_rem;
          r_crc_valid <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign crc_out   = r_crc_out;
  assign crc_valid = r_crc_valid;

endmodule

// File: tb/tb_pak_crc_sequencer.sv
// Bench for pak_crc_sequencer: a CRC-8 (poly 0x85) stage stub plus a
// polynomial-division reference model, driven with directed and random blocks.
module tb_pak_crc_sequencer;

  localparam int unsigned BB = 9;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_byte = '0;
  logic       in_ready, crc_clr, crc_en, crc_bit, crc_valid, busy;
  logic [7:0] crc_rem, crc_out;

  logic       s1 = 1'b0;
  logic       v1 = 1'b0;
  logic [7:0] b1 = '0;
  logic       ready1, clr1, en1, bit1, valid1, busy1;
  logic [7:0] rem1, out1;

  always #5 clk = ~clk;

  pak_crc_sequencer #(.BLOCK_BYTES(BB)) u_dut (
    .clk(clk), .reset(reset), .start(start), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .crc_clr(crc_clr), .crc_en(crc_en), .crc_bit(crc_bit),
    .crc_rem(crc_rem), .crc_out(crc_out), .crc_valid(crc_valid), .busy(busy)
  );

  pak_crc_sequencer #(.BLOCK_BYTES(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(s1), .in_byte(b1), .in_valid(v1),
    .in_ready(ready1), .crc_clr(clr1), .crc_en(en1), .crc_bit(bit1),
    .crc_rem(rem1), .crc_out(out1), .crc_valid(valid1), .busy(busy1)
  );

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    return {c[6:0], b} ^ (c[7] ? 8'h85 : 8'h00);
  endfunction

  // Downstream CRC stage stubs
  logic [7:0] r_rem = '0;
  logic [7:0] r_rem1 = '0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rem  <= '0;
      r_rem1 <= '0;
    end else begin
      if (crc_clr) r_rem <= '0;
      else if (crc_en) r_rem <= crc_step(r_rem, crc_bit);
      if (clr1) r_rem1 <= '0;
      else if (en1) r_rem1 <= crc_step(r_rem1, bit1);
    end
  end
  assign crc_rem = r_rem;
  assign rem1    = r_rem1;

  int   en_cnt = 0, clr_cnt = 0, clr_at = 0;
  int   en1_cnt = 0, clr1_cnt = 0, clr1_at = 0;
  logic bits[$];
  logic bits1[$];
  always @(posedge clk) begin
    if (crc_clr) begin
      clr_cnt <= clr_cnt + 1;
      clr_at  <= en_cnt;
    end
    if (crc_en) begin
      en_cnt <= en_cnt + 1;
      bits.push_back(crc_bit);
    end
    if (clr1) begin
      clr1_cnt <= clr1_cnt + 1;
      clr1_at  <= en1_cnt;
    end
    if (en1) begin
      en1_cnt <= en1_cnt + 1;
      bits1.push_back(bit1);
    end
  end

  // Reference: remainder of (message * x^8) divided by x^8 + 0x85
  function automatic logic [7:0] crc_ref(input logic [7:0] d[$]);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i <= d.size(); i++) begin
      r = {r[7:0], (i < d.size()) ? d[i] : 8'h00};
      for (int b = 15; b >= 8; b--) begin
        if (r[b]) r = r ^ (16'h0185 << (b - 8));
      end
    end
    return r[7:0];
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] data[$];
  int         gaps[$];
  int         mid_start_at = -1;
  int         abort_after = -1;
  int         hold_bad = 0;
  int         gap_en = 0;

  // status: 0 timeout, 1 crc_valid seen, 2 aborted on request
  task automatic run_block(input logic [7:0] prev, output int lat, output int status);
    int idx = 0;
    int g;
    int n;
    bit hs, wasload;
    n = data.size();
    lat = 0;
    status = 0;
    g = gaps[0];
    in_byte = data[0];
    in_valid = (g == 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 5000; cyc++) begin
      hs = in_ready && in_valid;
      wasload = in_ready;
      if (in_ready && !in_valid && crc_en) gap_en++;
      if (crc_out !== prev) hold_bad++;
      start = (cyc == mid_start_at);
      tick();
      if (hs) begin
        idx++;
        if (idx < n) begin
          in_byte = data[idx];
          g = gaps[idx];
        end
      end else if (wasload && g > 0) begin
        g--;
      end
      in_valid = (idx < n) && (g == 0);
      if (abort_after >= 0 && idx == abort_after && crc_en) begin
        status = 2;
        start = 1'b0;
        return;
      end
      if (crc_valid) begin
        status = 1;
        lat = cyc;
        start = 1'b0;
        in_valid = 1'b0;
        return;
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic do_block(input string tag);
    int en0, clr0, b0, lat, status, gsum, bad;
    logic [7:0] prev;
    logic exp_bits[$];
    en0 = en_cnt;
    clr0 = clr_cnt;
    b0 = bits.size();
    prev = crc_out;
    gsum = 0;
    bad = 0;
    foreach (gaps[i]) gsum += gaps[i];
    hold_bad = 0;
    gap_en = 0;
    run_block(prev, lat, status);
    check({tag, " done"}, status, 1);
    check({tag, " latency"}, lat, 1 + 9 * BB + 9 + gsum);
    check({tag, " crc_out"}, crc_out, crc_ref(data));
    check({tag, " en edges"}, en_cnt - en0, 8 * BB + 8);
    check({tag, " clr count"}, clr_cnt - clr0, 1);
    check({tag, " clr before en"}, clr_at, en0);
    foreach (data[i]) for (int b = 7; b >= 0; b--) exp_bits.push_back(data[i][b]);
    for (int b = 0; b < 8; b++) exp_bits.push_back(1'b0);
    check({tag, " bit count"}, bits.size() - b0, exp_bits.size());
    foreach (exp_bits[i]) begin
      if (b0 + i >= bits.size() || bits[b0 + i] !== exp_bits[i]) bad++;
    end
    check({tag, " bit stream"}, bad, 0);
    check({tag, " crc_out hold"}, hold_bad, 0);
    check({tag, " gap crc_en"}, gap_en, 0);
  endtask

  initial begin
    int lat, status, bad;
    logic [7:0] d1[$];
    logic exp1[$];

    #2;
    check("rst in_ready", in_ready, 0);
    check("rst crc_clr", crc_clr, 0);
    check("rst crc_en", crc_en, 0);
    check("rst crc_bit", crc_bit, 0);
    check("rst crc_out", crc_out, 8'h00);
    check("rst crc_valid", crc_valid, 0);
    check("rst busy", busy, 0);
    check("rst busy1", busy1, 0);
    #10;
    reset = 1'b1;
    tick();
    tick();

    data = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    gaps = {0, 0, 0, 0, 0, 0, 0, 0, 0};
    do_block("ascii");
    tick();
    check("valid pulse width", crc_valid, 0);
    check("idle after block", busy, 0);

    gaps = {0, 0, 0, 20, 0, 0, 0, 0, 0};
    mid_start_at = 30;
    do_block("gap+start");
    mid_start_at = -1;
    tick();

    for (int r = 0; r < 3; r++) begin
      data.delete();
      gaps.delete();
      for (int i = 0; i < int'(BB); i++) begin
        data.push_back(8'($urandom_range(0, 255)));
        gaps.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0);
      end
      do_block($sformatf("rand%0d", r));
      repeat ($urandom_range(0, 3)) tick();
    end

    for (int r = 0; r < 2; r++) begin
      data.delete();
      gaps.delete();
      for (int i = 0; i < int'(BB); i++) begin
        data.push_back(8'($urandom_range(0, 255)));
        gaps.push_back(0);
      end
      do_block($sformatf("b2b%0d", r));
    end
    tick();

    // Abort mid-shift of the fifth byte
    data = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    gaps = {0, 0, 0, 0, 0, 0, 0, 0, 0};
    abort_after = 5;
    run_block(crc_out, lat, status);
    abort_after = -1;
    check("abort reached", status, 2);
    repeat (3) begin
      @(negedge clk);
      if (!crc_en) break;
    end
    #1;
    reset = 1'b0;
    #1;
    check("abort in_ready", in_ready, 0);
    check("abort crc_en", crc_en, 0);
    check("abort crc_bit", crc_bit, 0);
    check("abort crc_clr", crc_clr, 0);
    check("abort crc_out", crc_out, 8'h00);
    check("abort crc_valid", crc_valid, 0);
    check("abort busy", busy, 0);
    #3;
    reset = 1'b1;
    tick();
    check("post-abort busy", busy, 0);
    bad = 0;
    for (int i = 0; i < 120; i++) begin
      if (crc_valid || busy) bad++;
      tick();
    end
    check("post-abort quiet", bad, 0);

    // Single-byte block on the BLOCK_BYTES=1 instance
    d1 = {8'hA5};
    s1 = 1'b1;
    v1 = 1'b1;
    b1 = 8'hA5;
    tick();
    s1 = 1'b0;
    status = 0;
    lat = 0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      tick();
      if (valid1) begin
        status = 1;
        lat = cyc;
        break;
      end
    end
    v1 = 1'b0;
    check("bb1 done", status, 1);
    check("bb1 latency", lat, 19);
    check("bb1 crc_out", out1, crc_ref(d1));
    check("bb1 clr count", clr1_cnt, 1);
    check("bb1 clr before en", clr1_at, 0);
    exp1 = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    check("bb1 bit count", bits1.size(), 16);
    bad = 0;
    foreach (exp1[i]) if (i >= bits1.size() || bits1[i] !== exp1[i]) bad++;
    check("bb1 bit stream", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
